multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port Instr, input, 32 bits: instruction register contents; uses opcode [6:0], funct3 [14:12] and funct7 [31:25].
REQ-004 SHALL have ports Zero and Negative, inputs, 1 bit each: ALU flags from the current cycle.
REQ-005 SHALL have port mem_ready, input, 1 bit: memory completes the access this cycle.
REQ-006 SHALL have strobe outputs PCWrite, IRWrite, MemWrite and RegWrite, 1 bit each.
REQ-007 SHALL have output AdrSrc, 1 bit: 0 = PC, 1 = ALUOut.
REQ-008 SHALL have output ALUSrcA, 2 bits: 00 = PC, 01 = OldPC, 10 = RD1.
REQ-009 SHALL have output ALUSrcB, 2 bits: 00 = RD2, 01 = ImmExt, 10 = constant 4.
REQ-010 SHALL have output ResultSrc, 2 bits: 00 = ALUOut, 01 = Data, 10 = ALUResult, 11 = ImmExt.
REQ-011 SHALL have output ALUControl, 5 bits: add 00010, sub 01010, or 00111, and 00011, sll 00000, srl 10000, slt 00001.
REQ-012 SHALL have output ImmSrc, 3 bits: I 000, S 001, B 010, U 011, J 100; decoded from opcode in every state.
REQ-013 SHALL have output state, 4 bits: current FSM state, for debug.

Function
REQ-014 SHALL implement FSM states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH, JAL, JALR, LUI.
REQ-015 SHALL in FETCH drive AdrSrc=0, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10, with IRWrite=PCWrite=mem_ready; it SHALL stay in FETCH until mem_ready=1, then go to DECODE.
REQ-016 SHALL in DECODE drive ALUSrcA=01, ALUSrcB=01, add, then branch on opcode:
- lw/sw (0000011/0100011) -> MEMADR
- R-type 0110011 -> EXECUTER
- I-type 0010011 -> EXECUTEI
- 1100011 -> BRANCH
- 1101111 -> JAL
- 1100111 -> JALR
- 0110111 -> LUI
- any other opcode -> FETCH, with no strobes asserted.
REQ-017 SHALL in MEMADR drive ALUSrcA=10, ALUSrcB=01, add; next state MEMREAD for lw, MEMWRITE for sw.
REQ-018 SHALL in MEMREAD drive AdrSrc=1, ResultSrc=00, and hold until mem_ready=1, then go to MEMWB.
REQ-019 SHALL in MEMWB drive ResultSrc=01, RegWrite=1, then go to FETCH.
REQ-020 SHALL in MEMWRITE drive AdrSrc=1, ResultSrc=00, MemWrite=1, and hold until mem_ready=1, then go to FETCH.
REQ-021 SHALL in EXECUTER drive ALUSrcA=10, ALUSrcB=00, ALUControl from funct3/funct7 (sub only when funct3=000 and funct7=0100000; unknown funct3 gives 00000); next state ALUWB.
REQ-022 SHALL in EXECUTEI behave like EXECUTER but with ALUSrcB=01 and funct7 ignored; next state ALUWB.
REQ-023 SHALL in ALUWB drive ResultSrc=00, RegWrite=1, then go to FETCH.
REQ-024 SHALL in BRANCH drive ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00.
- PCWrite SHALL be beq:Zero, bne:!Zero, blt:Negative, bge:!Negative, and 0 for any other funct3.
- Next state FETCH.
REQ-025 SHALL in JALR drive ALUSrcA=10, ALUSrcB=01, add, then go to JAL.
REQ-026 SHALL in JAL drive ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1, then go to ALUWB.
REQ-027 SHALL in LUI drive ResultSrc=11, RegWrite=1, then go to FETCH.
REQ-028 SHALL deassert every strobe not named for the current state; IRWrite and PCWrite in FETCH and PCWrite in BRANCH are the only input-dependent outputs.
REQ-029 SHALL give instruction latency: lw 5, sw 4 (each plus memory wait cycles), R/I-type 4, branch 3, jal 4, jalr 5, lui 3.

Reset
REQ-030 SHALL, while rst_n=0, force state=FETCH and hold all strobes at 0 regardless of mem_ready.
REQ-031 SHALL, when reset is asserted mid-instruction, abort the instruction and drop any in-progress MemWrite or RegWrite within the same cycle.
REQ-032 SHALL drive the FETCH mux and ALUControl values of REQ-015 during reset.

Configuration
REQ-033 SHALL, with PERF_COUNTER_EN defined, add 32-bit outputs cycle_count and instret_count, both reset to 0.
- cycle_count increments every cycle.
- instret_count increments on every transition into FETCH from a state other than FETCH.
- Both counters wrap from 0xFFFFFFFF to 0.
REQ-034 SHALL, without PERF_COUNTER_EN, have neither the counter ports nor the counter registers.

Structure
REQ-035 SHALL place the state enum, opcode constants and ALUControl constants in the shared package riscv_pkg.
REQ-036 SHALL implement funct3/funct7 decoding in a combinational sub-module alu_decoder.

Verification
REQ-037 SHALL check lw (0x00002083) with mem_ready low for 2 cycles: FETCH, DECODE, MEMADR, MEMREAD x3, MEMWB; RegWrite=1 for exactly one cycle.
REQ-038 SHALL check sub (0x40208033): ALUControl=01010 in EXECUTER and RegWrite=1 in ALUWB, 4 cycles total.
REQ-039 SHALL check beq with Zero=1 (PCWrite=1 in BRANCH) and bne with Zero=1 (PCWrite=0).
REQ-040 SHALL check jalr: state sequence DECODE, JALR, JAL, ALUWB, FETCH, with PCWrite=1 only in JAL.
REQ-041 SHALL check rst_n low during MEMWRITE: MemWrite goes to 0 immediately and state=FETCH.
REQ-042 SHALL check, with PERF_COUNTER_EN, that after 3 add instructions instret_count=3 and cycle_count=12.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the multicycle RISC-V controller: FSM state
// encoding, opcode values, datapath mux selects and ALU operation codes.
package riscv_pkg;

    // FSM states; the 4-bit encoding is visible on the debug state port.
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        JAL      = 4'd10,
        JALR     = 4'd11,
        LUI      = 4'd12
    } state_t;

    // Opcodes recognised by the decoder.
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    // ALU operation codes.
    localparam logic [4:0] ALU_ADD = 5'b00010;
    localparam logic [4:0] ALU_SUB = 5'b01010;
    localparam logic [4:0] ALU_OR  = 5'b00111;
    localparam logic [4:0] ALU_AND = 5'b00011;
    localparam logic [4:0] ALU_SLL = 5'b00000;
    localparam logic [4:0] ALU_SRL = 5'b10000;
    localparam logic [4:0] ALU_SLT = 5'b00001;

    // Datapath mux selects.
    localparam logic [1:0] SRCA_PC     = 2'b00;
    localparam logic [1:0] SRCA_OLDPC  = 2'b01;
    localparam logic [1:0] SRCA_RD1    = 2'b10;
    localparam logic [1:0] SRCB_RD2    = 2'b00;
    localparam logic [1:0] SRCB_IMM    = 2'b01;
    localparam logic [1:0] SRCB_FOUR   = 2'b10;
    localparam logic [1:0] RES_ALUOUT  = 2'b00;
    localparam logic [1:0] RES_DATA    = 2'b01;
    localparam logic [1:0] RES_ALURES  = 2'b10;
    localparam logic [1:0] RES_IMM     = 2'b11;

    // Immediate formats.
    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    // Immediate format implied by an opcode; unknown opcodes fall back to I.
    function automatic logic [2:0] imm_src_of(input logic [6:0] opcode);
        case (opcode)
            OP_STORE:  return IMM_S;
            OP_BRANCH: return IMM_B;
            OP_LUI:    return IMM_U;
            OP_JAL:    return IMM_J;
            default:   return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU operation decode from funct3/funct7. funct7 only matters for R-type
// instructions, where it separates sub from add.
module alu_decoder
    import riscv_pkg::*;
(
    input  logic [2:0] funct3_i,
    input  logic [6:0] funct7_i,
    input  logic       use_funct7_i,
    output logic [4:0] alu_control_o
);

    // Map funct3 to an ALU operation; unlisted funct3 values select 00000.
    always_comb begin
        // NOTE: every always_comb output gets a value before any branch so no latch is inferred.
        alu_control_o = ALU_SLL;
        case (funct3_i)
            3'b000:  alu_control_o = (use_funct7_i && funct7_i == 7'b0100000) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_control_o = ALU_SLL;
            3'b010:  alu_control_o = ALU_SLT;
            3'b101:  alu_control_o = ALU_SRL;
            3'b110:  alu_control_o = ALU_OR;
            3'b111:  alu_control_o = ALU_AND;
            default: alu_control_o = ALU_SLL;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of a multicycle RISC-V datapath. Mux selects follow the
// current state; strobes are gated by rst_n so they fall the moment reset
// asserts. Defining PERF_COUNTER_EN adds free-running cycle and retired-
// instruction counters.
module multicycle_controller
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] Instr,
    input  logic        Zero,
    input  logic        Negative,
    input  logic        mem_ready,
    output logic        PCWrite,
    output logic        IRWrite,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic        AdrSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [4:0]  ALUControl,
    output logic [2:0]  ImmSrc,
    output logic [3:0]  state
`ifdef PERF_COUNTER_EN
    ,
    output logic [31:0] cycle_count,
    output logic [31:0] instret_count
`endif
);

    state_t     state_q, state_d;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [4:0] alu_op;
    logic       pc_write_c, ir_write_c, mem_write_c, reg_write_c;
    logic       branch_taken;
    logic       unused_instr_bits;

    assign opcode            = Instr[6:0];
    assign funct3            = Instr[14:12];
    assign unused_instr_bits = ^{Instr[24:15], Instr[11:7]};

    alu_decoder u_alu_decoder (
        .funct3_i      (funct3),
        .funct7_i      (Instr[31:25]),
        .use_funct7_i  (state_q == EXECUTER),
        .alu_control_o (alu_op)
    );

    assign ImmSrc = imm_src_of(opcode);
    assign state  = state_q;

    // Branch condition selected by funct3; unsupported compares never branch.
    always_comb begin
        branch_taken = 1'b0;
        case (funct3)
            3'b000:  branch_taken = Zero;
            3'b001:  branch_taken = !Zero;
            3'b100:  branch_taken = Negative;
            3'b101:  branch_taken = !Negative;
            default: branch_taken = 1'b0;
        endcase
    end

    // Next-state and per-state control decode.
    always_comb begin
        state_d     = state_q;
        pc_write_c  = 1'b0;
        ir_write_c  = 1'b0;
        mem_write_c = 1'b0;
        reg_write_c = 1'b0;
        AdrSrc      = 1'b0;
        ALUSrcA     = SRCA_PC;
        ALUSrcB     = SRCB_RD2;
        ResultSrc   = RES_ALUOUT;
        ALUControl  = ALU_ADD;
        case (state_q)
            FETCH: begin
                ALUSrcB    = SRCB_FOUR;
                ResultSrc  = RES_ALURES;
                ir_write_c = mem_ready;
                pc_write_c = mem_ready;
                if (mem_ready) state_d = DECODE;
            end
            DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = MEMADR;
                    OP_RTYPE:          state_d = EXECUTER;
                    OP_ITYPE:          state_d = EXECUTEI;
                    OP_BRANCH:         state_d = BRANCH;
                    OP_JAL:            state_d = JAL;
                    OP_JALR:           state_d = JALR;
                    OP_LUI:            state_d = LUI;
                    default:           state_d = FETCH;
                endcase
            end
            MEMADR: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
                state_d = (opcode == OP_LOAD) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                AdrSrc = 1'b1;
                if (mem_ready) state_d = MEMWB;
            end
            MEMWB: begin
                ResultSrc   = RES_DATA;
                reg_write_c = 1'b1;
                state_d     = FETCH;
            end
            MEMWRITE: begin
                AdrSrc      = 1'b1;
                mem_write_c = 1'b1;
                if (mem_ready) state_d = FETCH;
            end
            EXECUTER: begin
                ALUSrcA    = SRCA_RD1;
                ALUControl = alu_op;
                state_d    = ALUWB;
            end
            EXECUTEI: begin
                ALUSrcA    = SRCA_RD1;
                ALUSrcB    = SRCB_IMM;
                ALUControl = alu_op;
                state_d    = ALUWB;
            end
            ALUWB: begin
                reg_write_c = 1'b1;
                state_d     = FETCH;
            end
            BRANCH: begin
                ALUSrcA    = SRCA_RD1;
                ALUControl = ALU_SUB;
                pc_write_c = branch_taken;
                state_d    = FETCH;
            end
            JALR: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
                state_d = JAL;
            end
            JAL: begin
                ALUSrcA    = SRCA_OLDPC;
                ALUSrcB    = SRCB_FOUR;
                pc_write_c = 1'b1;
                state_d    = ALUWB;
            end
            LUI: begin
                ResultSrc   = RES_IMM;
                reg_write_c = 1'b1;
                state_d     = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

    // Strobes are masked combinationally so reset silences them without waiting for a clock.
    assign PCWrite  = pc_write_c  & rst_n;
    assign IRWrite  = ir_write_c  & rst_n;
    assign MemWrite = mem_write_c & rst_n;
    assign RegWrite = reg_write_c & rst_n;

    // State register; reset aborts any instruction and returns to FETCH.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n) state_q <= FETCH;
        else        state_q <= state_d;
    end

`ifdef PERF_COUNTER_EN
    logic [31:0] cycle_count_q, instret_count_q;

    // Cycle counter and retired-instruction counter (counts each return to FETCH).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_count_q   <= 32'd0;
            instret_count_q <= 32'd0;
        end else begin
            cycle_count_q <= cycle_count_q + 32'd1;
            if (state_q != FETCH && state_d == FETCH)
                instret_count_q <= instret_count_q + 32'd1;
        end
    end

    assign cycle_count   = cycle_count_q;
    assign instret_count = instret_count_q;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed-vector bench for multicycle_controller. Inputs change and outputs
// are sampled in the low half of the clock. Counter checks compile in only
// when PERF_COUNTER_EN is defined.
module tb_multicycle_controller;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] Instr;
    logic        Zero, Negative, mem_ready;
    logic        PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc;
    logic [1:0]  ALUSrcA, ALUSrcB, ResultSrc;
    logic [4:0]  ALUControl;
    logic [2:0]  ImmSrc;
    logic [3:0]  state;
`ifdef PERF_COUNTER_EN
    logic [31:0] cycle_count, instret_count;
`endif

    int tests  = 0;
    int failed = 0;
    int rw_cnt;

    localparam logic [31:0] I_LW   = 32'h0000_2083;
    localparam logic [31:0] I_SW   = 32'h0020_A023;
    localparam logic [31:0] I_SUB  = 32'h4020_8033;
    localparam logic [31:0] I_ADD  = 32'h0020_8033;
    localparam logic [31:0] I_ADDI = 32'h4000_8093;
    localparam logic [31:0] I_JALR = 32'h0000_80E7;
    localparam logic [31:0] I_LUI  = 32'h0000_10B7;
    localparam logic [31:0] I_BAD  = 32'h0000_000B;

    typedef struct {
        logic [31:0] instr;
        logic        zero;
        logic        neg;
        logic        pcw;
    } br_vec_t;

    br_vec_t br_tab [6];

    multicycle_controller dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .Instr      (Instr),
        .Zero       (Zero),
        .Negative   (Negative),
        .mem_ready  (mem_ready),
        .PCWrite    (PCWrite),
        .IRWrite    (IRWrite),
        .MemWrite   (MemWrite),
        .RegWrite   (RegWrite),
        .AdrSrc     (AdrSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ResultSrc  (ResultSrc),
        .ALUControl (ALUControl),
        .ImmSrc     (ImmSrc),
        .state      (state)
`ifdef PERF_COUNTER_EN
        ,
        .cycle_count   (cycle_count),
        .instret_count (instret_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock, drive mem_ready for the new cycle, then check the state.
    task automatic expect_cycle(input string tag, input state_t exp, input logic mr);
        @(negedge clk);
        mem_ready = mr;
        #1;
        check(tag, 32'(state), 32'(exp));
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_state", 32'(state), 32'(FETCH));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        br_tab[0] = '{32'h0020_8063, 1'b1, 1'b0, 1'b1}; // beq, Zero=1
        br_tab[1] = '{32'h0020_9063, 1'b1, 1'b0, 1'b0}; // bne, Zero=1
        br_tab[2] = '{32'h0020_9063, 1'b0, 1'b0, 1'b1}; // bne, Zero=0
        br_tab[3] = '{32'h0020_C063, 1'b0, 1'b1, 1'b1}; // blt, Negative=1
        br_tab[4] = '{32'h0020_D063, 1'b0, 1'b1, 1'b0}; // bge, Negative=1
        br_tab[5] = '{32'h0020_A063, 1'b1, 1'b1, 1'b0}; // unsupported funct3

        rst_n = 1'b0; Instr = I_LW; Zero = 1'b0; Negative = 1'b0; mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_state",  32'(state), 32'(FETCH));
        check("rst_irw",    32'(IRWrite), 32'd0);
        check("rst_pcw",    32'(PCWrite), 32'd0);
        check("rst_srcb",   32'(ALUSrcB), 32'(2'b10));
        check("rst_res",    32'(ResultSrc), 32'(2'b10));
        check("rst_aluctl", 32'(ALUControl), 32'(5'b00010));

        // lw with two memory wait cycles.
        release_reset();
        check("lw_f_irw", 32'(IRWrite), 32'd1);
        check("lw_f_pcw", 32'(PCWrite), 32'd1);
        check("lw_f_adr", 32'(AdrSrc), 32'd0);
        rw_cnt = 0;
        expect_cycle("lw_dec", DECODE, 1'b1);
        rw_cnt += int'(RegWrite);
        check("lw_dec_a", 32'(ALUSrcA), 32'(2'b01));
        check("lw_dec_b", 32'(ALUSrcB), 32'(2'b01));
        check("lw_dec_pcw", 32'(PCWrite), 32'd0);
        expect_cycle("lw_adr", MEMADR, 1'b1);
        rw_cnt += int'(RegWrite);
        check("lw_adr_a", 32'(ALUSrcA), 32'(2'b10));
        expect_cycle("lw_rd0", MEMREAD, 1'b0);
        rw_cnt += int'(RegWrite);
        check("lw_rd_adr", 32'(AdrSrc), 32'd1);
        expect_cycle("lw_rd1", MEMREAD, 1'b0);
        rw_cnt += int'(RegWrite);
        expect_cycle("lw_rd2", MEMREAD, 1'b1);
        rw_cnt += int'(RegWrite);
        check("lw_rd_irw", 32'(IRWrite), 32'd0);
        expect_cycle("lw_wb", MEMWB, 1'b1);
        rw_cnt += int'(RegWrite);
        check("lw_wb_res", 32'(ResultSrc), 32'(2'b01));
        expect_cycle("lw_end", FETCH, 1'b1);
        rw_cnt += int'(RegWrite);
        check("lw_rw_once", 32'(rw_cnt), 32'd1);

        // sub: R-type with funct7=0100000.
        Instr = I_SUB;
        expect_cycle("sub_dec", DECODE, 1'b1);
        expect_cycle("sub_ex", EXECUTER, 1'b1);
        check("sub_aluctl", 32'(ALUControl), 32'(5'b01010));
        check("sub_b", 32'(ALUSrcB), 32'(2'b00));
        expect_cycle("sub_wb", ALUWB, 1'b1);
        check("sub_rw", 32'(RegWrite), 32'd1);
        expect_cycle("sub_end", FETCH, 1'b1);

        // addi with immediate bits that mimic funct7=0100000: still add.
        Instr = I_ADDI;
        expect_cycle("addi_dec", DECODE, 1'b1);
        expect_cycle("addi_ex", EXECUTEI, 1'b1);
        check("addi_aluctl", 32'(ALUControl), 32'(5'b00010));
        check("addi_b", 32'(ALUSrcB), 32'(2'b01));
        expect_cycle("addi_wb", ALUWB, 1'b1);
        expect_cycle("addi_end", FETCH, 1'b1);

        // Branch table.
        foreach (br_tab[i]) begin
            Instr = br_tab[i].instr; Zero = br_tab[i].zero; Negative = br_tab[i].neg;
            expect_cycle($sformatf("br%0d_dec", i), DECODE, 1'b1);
            expect_cycle($sformatf("br%0d_st", i), BRANCH, 1'b1);
            check($sformatf("br%0d_pcw", i), 32'(PCWrite), 32'(br_tab[i].pcw));
            check($sformatf("br%0d_alu", i), 32'(ALUControl), 32'(5'b01010));
            check($sformatf("br%0d_imm", i), 32'(ImmSrc), 32'(3'b010));
            expect_cycle($sformatf("br%0d_end", i), FETCH, 1'b1);
        end
        Zero = 1'b0; Negative = 1'b0;

        // jalr: DECODE, JALR, JAL, ALUWB, FETCH; PCWrite only in JAL.
        Instr = I_JALR;
        expect_cycle("jalr_dec", DECODE, 1'b1);
        expect_cycle("jalr_st", JALR, 1'b1);
        check("jalr_pcw", 32'(PCWrite), 32'd0);
        check("jalr_a", 32'(ALUSrcA), 32'(2'b10));
        expect_cycle("jalr_jal", JAL, 1'b1);
        check("jal_pcw", 32'(PCWrite), 32'd1);
        check("jal_b", 32'(ALUSrcB), 32'(2'b10));
        expect_cycle("jalr_wb", ALUWB, 1'b1);
        check("jalr_wb_pcw", 32'(PCWrite), 32'd0);
        expect_cycle("jalr_end", FETCH, 1'b1);

        // lui: 3 cycles, result from immediate.
        Instr = I_LUI;
        #1;
        check("lui_f_imm", 32'(ImmSrc), 32'(3'b011));
        expect_cycle("lui_dec", DECODE, 1'b1);
        expect_cycle("lui_st", LUI, 1'b1);
        check("lui_res", 32'(ResultSrc), 32'(2'b11));
        check("lui_rw", 32'(RegWrite), 32'd1);
        expect_cycle("lui_end", FETCH, 1'b1);

        // Unknown opcode returns straight to FETCH.
        Instr = I_BAD;
        expect_cycle("bad_dec", DECODE, 1'b1);
        expect_cycle("bad_end", FETCH, 1'b1);

        // sw interrupted by reset while waiting in MEMWRITE.
        Instr = I_SW;
        expect_cycle("sw_dec", DECODE, 1'b1);
        expect_cycle("sw_adr", MEMADR, 1'b1);
        expect_cycle("sw_wr", MEMWRITE, 1'b0);
        check("sw_memw", 32'(MemWrite), 32'd1);
        check("sw_imm", 32'(ImmSrc), 32'(3'b001));
        rst_n = 1'b0; mem_ready = 1'b1;
        #1;
        check("sw_rst_memw", 32'(MemWrite), 32'd0);
        check("sw_rst_state", 32'(state), 32'(FETCH));
        check("sw_rst_irw", 32'(IRWrite), 32'd0);

        // Three adds straight out of reset: 12 cycles, 3 retired.
        Instr = I_ADD;
        release_reset();
`ifdef PERF_COUNTER_EN
        check("perf_cyc0", cycle_count, 32'd0);
        check("perf_ret0", instret_count, 32'd0);
`endif
        for (int k = 0; k < 3; k++) begin
            expect_cycle($sformatf("add%0d_dec", k), DECODE, 1'b1);
            expect_cycle($sformatf("add%0d_ex", k), EXECUTER, 1'b1);
            check($sformatf("add%0d_alu", k), 32'(ALUControl), 32'(5'b00010));
            expect_cycle($sformatf("add%0d_wb", k), ALUWB, 1'b1);
            expect_cycle($sformatf("add%0d_end", k), FETCH, 1'b1);
        end
`ifdef PERF_COUNTER_EN
        check("perf_cyc12", cycle_count, 32'd12);
        check("perf_ret3", instret_count, 32'd3);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
